// File: rtl/excp_ctrl_pkg.sv
// excp_ctrl_pkg: shared exception codes, CP0 addresses and field positions
package excp_ctrl_pkg;
   localparam int BIT_SYS  = 8;
   localparam int BIT_ERET = 12;
   localparam logic [31:0] ET_NONE = 32'd0;
   localparam logic [31:0] ET_INT  = 32'd1;
   localparam logic [31:0] ET_SYS  = 32'd8;
   localparam logic [31:0] ET_RI   = 32'd10;
   localparam logic [31:0] ET_OV   = 32'd12;
   localparam logic [31:0] ET_TRAP = 32'd13;
   localparam logic [31:0] ET_ERET = 32'd14;
   localparam logic [4:0] ADDR_STATUS = 5'd12;
   localparam logic [4:0] ADDR_CAUSE  = 5'd13;
   localparam logic [4:0] ADDR_EPC    = 5'd14;
   localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0020;
   localparam int ST_IE  = 0;
   localparam int ST_EXL = 1;
   localparam int IM_LO  = 8;
   localparam int IM_HI  = 15;
   typedef enum logic [1:0] {IDLE, FLUSH, BLANK} state_t;
   // f holds flag bits 12:8 (syscall, ri, trap, ov, eret); first match wins
   function automatic logic [31:0] exc_type(input logic irq, input logic [4:0] f);
      return irq ? ET_INT : f[0] ? ET_SYS : f[1] ? ET_RI : f[2] ? ET_TRAP :
             f[3] ? ET_OV : f[4] ? ET_ERET : ET_NONE;
   endfunction
endpackage

// File: rtl/excp_cp0_fwd.sv
// excp_cp0_fwd: merges a pending WB mtc0 into the CP0 Status/Cause/EPC view
module excp_cp0_fwd
   import excp_ctrl_pkg::*;
(
   input  logic [31:0] cp0_status,
   input  logic [31:0] cp0_cause,
   input  logic [31:0] cp0_epc,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata,
   output logic [31:0] status,
   output logic [31:0] cause,
   output logic [31:0] epc
);
   // only IV/WP (23:22) and software IP (9:8) of Cause are writable by mtc0
   always_comb begin
      status = (we && waddr == ADDR_STATUS) ? wdata : cp0_status;
      cause  = (we && waddr == ADDR_CAUSE) ?
               {cp0_cause[31:24], wdata[23:22], cp0_cause[21:10], wdata[9:8], cp0_cause[7:0]} : cp0_cause;
      epc    = (we && waddr == ADDR_EPC) ? wdata : cp0_epc;
   end
endmodule

// File: rtl/excp_ctrl.sv
// excp_ctrl: exception/interrupt arbitration, flush/redirect and CP0 update strobes
module excp_ctrl
   import excp_ctrl_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF,
   parameter int          BLANK_CYCLES = 2
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid_i,
   input  logic [31:0] mem_excflags_i,
   input  logic [31:0] mem_pc_i,
   input  logic        mem_in_delayslot_i,
   input  logic [31:0] cp0_status_i,
   input  logic [31:0] cp0_cause_i,
   input  logic [31:0] cp0_epc_i,
   input  logic        wb_cp0_we_i,
   input  logic [4:0]  wb_cp0_waddr_i,
   input  logic [31:0] wb_cp0_data_i,
   output logic [31:0] excepttype_o,
   output logic        flush_o,
   output logic [31:0] new_pc_o,
   output logic        cp0_exc_we_o,
   output logic [31:0] cp0_epc_o,
   output logic [4:0]  cp0_exccode_o,
   output logic        cp0_bd_o,
   output logic        cp0_eret_o
);
   logic [31:0] status, cause, epc, etype;
   logic        irq, take, eret, exc, unused;
   state_t      state, state_n;
   logic [2:0]  cnt, cnt_n;

   excp_cp0_fwd u_fwd (
      .cp0_status(cp0_status_i),
      .cp0_cause(cp0_cause_i),
      .cp0_epc(cp0_epc_i),
      .we(wb_cp0_we_i),
      .waddr(wb_cp0_waddr_i),
      .wdata(wb_cp0_data_i),
      .status(status),
      .cause(cause),
      .epc(epc)
   );

   assign irq    = |(cause[IM_HI:IM_LO] & status[IM_HI:IM_LO]) && status[ST_IE] && !status[ST_EXL];
   assign etype  = exc_type(irq, mem_excflags_i[BIT_ERET:BIT_SYS]);
   assign take   = state == IDLE && mem_valid_i && etype != ET_NONE;
   assign eret   = etype == ET_ERET;
   assign exc    = take && !eret;
   assign unused = ^{mem_excflags_i, status, cause};

   // state and blanking counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   // next state: FLUSH lasts one cycle, BLANK lasts BLANK_CYCLES cycles
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      case (state)
         IDLE:    state_n = take ? FLUSH : IDLE;
         FLUSH: begin
            state_n = BLANK;
            cnt_n   = 3'(BLANK_CYCLES);
         end
         BLANK: begin
            cnt_n   = cnt - 3'd1;
            state_n = cnt == 3'd1 ? IDLE : BLANK;
         end
         default: state_n = IDLE;
      endcase
   end

   // registered outputs; strobes live one cycle, interrupts load ExcCode 0
   always_ff @(posedge clk) begin
      if (rst) begin
         excepttype_o  <= '0;
         flush_o       <= 1'b0;
         new_pc_o      <= '0;
         cp0_exc_we_o  <= 1'b0;
         cp0_epc_o     <= '0;
         cp0_exccode_o <= '0;
         cp0_bd_o      <= 1'b0;
         cp0_eret_o    <= 1'b0;
      end else begin
         if (take) excepttype_o <= etype;
         flush_o       <= take;
         new_pc_o      <= !take ? '0 : eret ? epc : EXC_VECTOR;
         cp0_exc_we_o  <= exc;
         cp0_epc_o     <= !exc ? '0 : mem_in_delayslot_i ? mem_pc_i - 32'd4 : mem_pc_i;
         cp0_exccode_o <= (exc && etype != ET_INT) ? etype[4:0] : 5'd0;
         cp0_bd_o      <= exc && mem_in_delayslot_i;
         cp0_eret_o    <= take && eret;
      end
   end
endmodule

// File: tb/tb_excp_ctrl.sv
// tb_excp_ctrl: directed scenarios plus randomized run against a behavioural model
module tb_excp_ctrl;
   localparam int B = 2;
   logic        clk = 1'b0, rst = 1'b1;
   logic        mem_valid_i, mem_in_delayslot_i, wb_cp0_we_i;
   logic [31:0] mem_excflags_i, mem_pc_i, cp0_status_i, cp0_cause_i, cp0_epc_i, wb_cp0_data_i;
   logic [4:0]  wb_cp0_waddr_i;
   logic [31:0] excepttype_o, new_pc_o, cp0_epc_o;
   logic        flush_o, cp0_exc_we_o, cp0_bd_o, cp0_eret_o;
   logic [4:0]  cp0_exccode_o;
   int checks = 0, errors = 0;

   excp_ctrl #(.EXC_VECTOR(32'h0000_0020), .BLANK_CYCLES(B)) dut (
      .clk(clk), .rst(rst),
      .mem_valid_i(mem_valid_i), .mem_excflags_i(mem_excflags_i), .mem_pc_i(mem_pc_i),
      .mem_in_delayslot_i(mem_in_delayslot_i),
      .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i),
      .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i), .wb_cp0_data_i(wb_cp0_data_i),
      .excepttype_o(excepttype_o), .flush_o(flush_o), .new_pc_o(new_pc_o),
      .cp0_exc_we_o(cp0_exc_we_o), .cp0_epc_o(cp0_epc_o), .cp0_exccode_o(cp0_exccode_o),
      .cp0_bd_o(cp0_bd_o), .cp0_eret_o(cp0_eret_o)
   );

   always #5 clk = ~clk;

   task automatic set_in(input logic v, input logic [31:0] f, pc, input logic ds,
                         input logic [31:0] st, ca, ep, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd);
      mem_valid_i = v; mem_excflags_i = f; mem_pc_i = pc; mem_in_delayslot_i = ds;
      cp0_status_i = st; cp0_cause_i = ca; cp0_epc_i = ep;
      wb_cp0_we_i = we; wb_cp0_waddr_i = wa; wb_cp0_data_i = wd;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (5) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_in(1, 32'h100, 32'h100, 0, 0, 0, 0, 0, 0, 0);
      tick(); tick();
      checks++; if ({flush_o, cp0_exc_we_o, cp0_eret_o, cp0_bd_o} !== 4'b0) begin errors++; $display("FAIL reset_strobes got %b want 0000", {flush_o, cp0_exc_we_o, cp0_eret_o, cp0_bd_o}); end
      checks++; if ({excepttype_o, new_pc_o, cp0_epc_o, cp0_exccode_o} !== 101'b0) begin errors++; $display("FAIL reset_values type=%h npc=%h epc=%h cc=%h want 0", excepttype_o, new_pc_o, cp0_epc_o, cp0_exccode_o); end
      rst = 1'b0;
      settle();
   endtask

   task automatic test_syscall();
      set_in(1, 32'h100, 32'h100, 0, 0, 0, 0, 0, 0, 0);
      tick();
      checks++; if (flush_o !== 1'b1 || new_pc_o !== 32'h20) begin errors++; $display("FAIL sys_flush flush=%b npc=%h want 1/00000020", flush_o, new_pc_o); end
      checks++; if (excepttype_o !== 32'd8 || cp0_exccode_o !== 5'd8) begin errors++; $display("FAIL sys_type type=%0d cc=%0d want 8/8", excepttype_o, cp0_exccode_o); end
      checks++; if (cp0_epc_o !== 32'h100 || cp0_bd_o !== 1'b0 || cp0_exc_we_o !== 1'b1 || cp0_eret_o !== 1'b0) begin errors++; $display("FAIL sys_cp0 epc=%h bd=%b we=%b eret=%b want 100/0/1/0", cp0_epc_o, cp0_bd_o, cp0_exc_we_o, cp0_eret_o); end
      for (int i = 0; i < B + 1; i++) begin
         tick();
         checks++; if (flush_o !== 1'b0 || cp0_exc_we_o !== 1'b0) begin errors++; $display("FAIL sys_blank%0d flush=%b we=%b want 0/0", i, flush_o, cp0_exc_we_o); end
      end
      tick();
      checks++; if (flush_o !== 1'b1) begin errors++; $display("FAIL sys_retake flush=%b want 1", flush_o); end
      settle();
   endtask

   task automatic test_ov_delayslot();
      set_in(1, 32'h800, 32'h204, 1, 0, 0, 0, 0, 0, 0);
      tick();
      checks++; if (cp0_epc_o !== 32'h200 || cp0_bd_o !== 1'b1 || excepttype_o !== 32'd12 || cp0_exccode_o !== 5'd12) begin errors++; $display("FAIL ov_ds epc=%h bd=%b type=%0d cc=%0d want 200/1/12/12", cp0_epc_o, cp0_bd_o, excepttype_o, cp0_exccode_o); end
      settle();
      set_in(1, 32'h200, 32'h0, 1, 0, 0, 0, 0, 0, 0);
      tick();
      checks++; if (cp0_epc_o !== 32'hFFFF_FFFC || cp0_bd_o !== 1'b1 || excepttype_o !== 32'd10) begin errors++; $display("FAIL ri_wrap epc=%h bd=%b type=%0d want fffffffc/1/10", cp0_epc_o, cp0_bd_o, excepttype_o); end
      settle();
   endtask

   task automatic test_int_priority();
      set_in(1, 32'h100, 32'h300, 0, 32'h0000_0401, 32'h0000_0400, 0, 0, 0, 0);
      tick();
      checks++; if (excepttype_o !== 32'd1 || cp0_exccode_o !== 5'd0 || flush_o !== 1'b1) begin errors++; $display("FAIL int_prio type=%0d cc=%0d flush=%b want 1/0/1", excepttype_o, cp0_exccode_o, flush_o); end
      checks++; if (cp0_epc_o !== 32'h300 || new_pc_o !== 32'h20) begin errors++; $display("FAIL int_epc epc=%h npc=%h want 300/20", cp0_epc_o, new_pc_o); end
      settle();
      set_in(1, 0, 32'h340, 0, 32'h0000_0101, 0, 0, 1, 5'd13, 32'h0000_0100);
      tick();
      checks++; if (flush_o !== 1'b1 || excepttype_o !== 32'd1) begin errors++; $display("FAIL int_fwd_swip flush=%b type=%0d want 1/1", flush_o, excepttype_o); end
      settle();
      set_in(1, 0, 32'h380, 0, 32'h0000_0401, 0, 0, 1, 5'd13, 32'h0000_0400);
      tick();
      checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL int_hwip_nowrite flush=%b want 0", flush_o); end
      settle();
   endtask

   task automatic test_eret_fwd();
      set_in(1, 32'h1000, 32'h500, 0, 0, 0, 32'h5678, 1, 5'd14, 32'h1234);
      tick();
      checks++; if (new_pc_o !== 32'h1234 || flush_o !== 1'b1) begin errors++; $display("FAIL eret_pc npc=%h flush=%b want 1234/1", new_pc_o, flush_o); end
      checks++; if (cp0_eret_o !== 1'b1 || cp0_exc_we_o !== 1'b0 || excepttype_o !== 32'd14) begin errors++; $display("FAIL eret_strobe eret=%b we=%b type=%0d want 1/0/14", cp0_eret_o, cp0_exc_we_o, excepttype_o); end
      settle();
   endtask

   task automatic test_int_masked();
      set_in(1, 0, 32'h600, 0, 32'h0000_0401, 32'h0000_0400, 0, 1, 5'd12, 32'h0000_0403);
      tick();
      checks++; if (flush_o !== 1'b0 || cp0_exc_we_o !== 1'b0) begin errors++; $display("FAIL int_exl_fwd flush=%b we=%b want 0/0", flush_o, cp0_exc_we_o); end
      set_in(0, 32'h100, 32'h600, 0, 0, 0, 0, 0, 0, 0);
      tick();
      checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL invalid_flags flush=%b want 0", flush_o); end
      settle();
   endtask

   task automatic test_reset_in_blank();
      set_in(1, 32'h100, 32'h700, 0, 0, 0, 0, 0, 0, 0);
      tick();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if ({flush_o, cp0_exc_we_o, cp0_eret_o, cp0_bd_o} !== 4'b0 || excepttype_o !== 32'd0 || cp0_epc_o !== 32'd0) begin errors++; $display("FAIL rst_blank flush=%b type=%0d epc=%h want 0", flush_o, excepttype_o, cp0_epc_o); end
      set_in(1, 32'h100, 32'h704, 0, 0, 0, 0, 0, 0, 0);
      tick();
      checks++; if (flush_o !== 1'b1 || excepttype_o !== 32'd8 || cp0_epc_o !== 32'h704) begin errors++; $display("FAIL rst_then_sys flush=%b type=%0d epc=%h want 1/8/704", flush_o, excepttype_o, cp0_epc_o); end
      settle();
   endtask

   task automatic test_random();
      int blank;
      logic [31:0] m_type, st, ca, ep, f, pc, wd, st_f, ca_f, ep_f, code, e_npc, e_epc;
      logic [4:0] wa, e_cc;
      logic v, ds, we, r, irq, tk, e_we, e_eret, e_bd;
      rst = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      rst = 1'b0;
      blank = 0;
      m_type = 0;
      for (int i = 0; i < 400; i++) begin
         r  = $urandom_range(0, 39) == 0;
         v  = $urandom_range(0, 3) != 0;
         f  = ($urandom & ~32'h1F00) | (($urandom_range(0, 1) == 0) ? ($urandom & 32'h1F00) : 32'h0);
         pc = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) * 4 : $urandom & ~32'h3;
         ds = 1'($urandom);
         st = $urandom; ca = $urandom; ep = $urandom; wd = $urandom;
         we = 1'($urandom);
         wa = 5'(12 + $urandom_range(0, 2));
         if ($urandom_range(0, 3) == 0) wa = 5'($urandom);
         rst = r;
         set_in(v, f, pc, ds, st, ca, ep, we, wa, wd);
         st_f = (we && wa == 5'd12) ? wd : st;
         ep_f = (we && wa == 5'd14) ? wd : ep;
         ca_f = ca;
         if (we && wa == 5'd13) begin
            ca_f[9:8] = wd[9:8];
            ca_f[23:22] = wd[23:22];
         end
         irq  = (((ca_f >> 8) & (st_f >> 8) & 32'hFF) != 0) && st_f[0] && !st_f[1];
         code = irq ? 1 : f[8] ? 8 : f[9] ? 10 : f[10] ? 13 : f[11] ? 12 : f[12] ? 14 : 0;
         tk = 1'b0;
         if (r) begin
            blank = 0;
            m_type = 0;
         end else if (blank > 0) blank--;
         else if (v && code != 0) begin
            tk = 1'b1;
            m_type = code;
            blank = 1 + B;
         end
         e_we   = tk && code != 14;
         e_eret = tk && code == 14;
         e_npc  = !tk ? 32'h0 : e_eret ? ep_f : 32'h20;
         e_epc  = !e_we ? 32'h0 : ds ? pc - 32'd4 : pc;
         e_bd   = e_we && ds;
         e_cc   = (e_we && code != 1) ? code[4:0] : 5'd0;
         tick();
         checks++; if (flush_o !== tk) begin errors++; $display("FAIL rnd%0d flush got %b want %b", i, flush_o, tk); end
         checks++; if (excepttype_o !== m_type) begin errors++; $display("FAIL rnd%0d type got %0d want %0d", i, excepttype_o, m_type); end
         checks++; if (new_pc_o !== e_npc) begin errors++; $display("FAIL rnd%0d new_pc got %h want %h", i, new_pc_o, e_npc); end
         checks++; if (cp0_exc_we_o !== e_we || cp0_eret_o !== e_eret) begin errors++; $display("FAIL rnd%0d we/eret got %b%b want %b%b", i, cp0_exc_we_o, cp0_eret_o, e_we, e_eret); end
         checks++; if (cp0_epc_o !== e_epc || cp0_bd_o !== e_bd) begin errors++; $display("FAIL rnd%0d epc/bd got %h/%b want %h/%b", i, cp0_epc_o, cp0_bd_o, e_epc, e_bd); end
         checks++; if (cp0_exccode_o !== e_cc) begin errors++; $display("FAIL rnd%0d exccode got %0d want %0d", i, cp0_exccode_o, e_cc); end
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_syscall();
      test_ov_delayslot();
      test_int_priority();
      test_eret_fwd();
      test_int_masked();
      test_reset_in_blank();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
